// File: rtl/shift_register_sipo_pkg.sv
// Shared constants for the serial-in / parallel-out register with output latch.
// WIDTH is the default register width used by every module in this slice.
package shift_register_sipo_pkg;

   localparam int WIDTH = 8;

endpackage : shift_register_sipo_pkg

// File: rtl/shift_register_sipo_if.sv
// Serial-side signals of the SIPO register: data bit, storage strobe and output enable.
// STCP is a level strobe: a transfer happens on the first SHCP edge that samples it high
// after it has been sampled low; DS and STCP must be stable around each rising SHCP edge.
interface shift_register_sipo_if;

   logic DS;
   logic STCP;
   logic OE_bar;

   modport master (
      output DS,
      output STCP,
      output OE_bar
   );

   modport slave (
      input DS,
      input STCP,
      input OE_bar
   );

endinterface : shift_register_sipo_if

// File: rtl/shift_register_sipo_core.sv
// Shift stage of the SIPO register: new bits enter at the MSB and move toward the LSB.
// The bit leaving sr[0] is dropped; there is no shift enable.
module shift_register_sipo_core #(
   parameter int WIDTH = shift_register_sipo_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   output logic [WIDTH-1:0] sr
);

   import shift_register_sipo_pkg::*;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr <= {din, sr[WIDTH-1:1]};
      end
   end

endmodule : shift_register_sipo_core

// File: rtl/shift_register_sipo.sv
// 74HC595-style SIPO: shift stage, storage latch loaded on a detected STCP rise,
// and a tri-state parallel output gated combinationally by OE_bar.
module shift_register_sipo #(
   parameter int WIDTH = shift_register_sipo_pkg::WIDTH
) (
   input  logic                    SHCP,
   input  logic                    MR_bar,
   shift_register_sipo_if.slave    bus,
   output wire  [WIDTH-1:0]        out
);

   import shift_register_sipo_pkg::*;

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] st;
   logic             stcp_q;
   logic             stcp_rise;

   shift_register_sipo_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk   (SHCP),
      .rst_n (MR_bar),
      .din   (bus.DS),
      .sr    (sr)
   );

   assign stcp_rise = bus.STCP & ~stcp_q;

   // st samples sr before this edge's shift, so the bit shifted in on the strobe edge is excluded.
   always_ff @(posedge SHCP) begin
      if (!MR_bar) begin
         st     <= '0;
         stcp_q <= 1'b0;
      end else begin
         stcp_q <= bus.STCP;
         if (stcp_rise) begin
            st <= sr;
         end
      end
   end

   assign out = bus.OE_bar ? {WIDTH{1'bz}} : st;

endmodule : shift_register_sipo

// File: tb/tb_shift_register_sipo.sv
// Directed bench for shift_register_sipo: reset, bit order, output enable, strobe edge,
// reset priority and mid-byte reset. Undriven output reads as all-ones through a pull-up.
module tb_shift_register_sipo;

   logic SHCP;
   logic MR_bar;
   tri1 [7:0] out;

   int tests_run;
   int tests_failed;

   shift_register_sipo_if bus ();

   shift_register_sipo #(
      .WIDTH (8)
   ) dut (
      .SHCP   (SHCP),
      .MR_bar (MR_bar),
      .bus    (bus),
      .out    (out)
   );

   // clock / reset
   initial begin
      SHCP = 1'b0;
      forever #5 SHCP = ~SHCP;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, required completion before 200000");
      $fatal(1, "watchdog expired");
   end

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic edge_with(input logic rst_n, input logic ds, input logic stcp);
      MR_bar   = rst_n;
      bus.DS   = ds;
      bus.STCP = stcp;
      @(posedge SHCP);
      #1;
   endtask

   task automatic shift_byte(input logic [7:0] bits);
      // bits[0] is shifted first and ends up at out[0]
      for (int i = 0; i < 8; i++) begin
         edge_with(1'b1, bits[i], 1'b0);
      end
   endtask

   task automatic strobe();
      edge_with(1'b1, 1'b0, 1'b1);
      edge_with(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      bus.OE_bar = 1'b0;
      edge_with(1'b0, 1'b1, 1'b1);
      tests_run++;
      if (out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_out: got %b, required %b", out, 8'h00);
      end
      bus.OE_bar = 1'b1;
      #1;
      tests_run++;
      if (out !== 8'hFF) begin
         tests_failed++;
         $display("FAIL reset_oe_off: got %b, required %b (undriven, pulled high)", out, 8'hFF);
      end
      bus.OE_bar = 1'b0;
   endtask

   task automatic test_shift();
      // 1,0,0,1,1,0,0,1 first to last; the strobe edge shifts a 0 that must not be stored
      shift_byte(8'b1001_1001);
      strobe();
      tests_run++;
      if (out !== 8'b1001_1001) begin
         tests_failed++;
         $display("FAIL shift_pattern: got %b, required %b", out, 8'b1001_1001);
      end
   endtask

   task automatic test_bit_order();
      // 1,1,0,0,0,0,0,0 first to last
      shift_byte(8'b0000_0011);
      strobe();
      tests_run++;
      if (out !== 8'b0000_0011) begin
         tests_failed++;
         $display("FAIL bit_order: got %b, required %b", out, 8'b0000_0011);
      end
   endtask

   task automatic test_output_enable();
      shift_byte(8'hA5);
      strobe();
      bus.OE_bar = 1'b1;
      #1;
      tests_run++;
      if (out !== 8'hFF) begin
         tests_failed++;
         $display("FAIL oe_off: got %h, required %h (undriven, pulled high)", out, 8'hFF);
      end
      bus.OE_bar = 1'b0;
      #1;
      tests_run++;
      if (out !== 8'hA5) begin
         tests_failed++;
         $display("FAIL oe_on: got %h, required %h", out, 8'hA5);
      end
      bus.OE_bar = 1'b1;
      #1;
      tests_run++;
      if (out !== 8'hFF) begin
         tests_failed++;
         $display("FAIL oe_off_again: got %h, required %h", out, 8'hFF);
      end
      // shifting new data while disabled must leave the latch alone
      shift_byte(8'h3C);
      bus.OE_bar = 1'b0;
      #1;
      tests_run++;
      if (out !== 8'hA5) begin
         tests_failed++;
         $display("FAIL oe_reenable: got %h, required %h", out, 8'hA5);
      end
   endtask

   task automatic test_strobe_hold();
      logic [7:0] exp_after [4];
      exp_after = '{8'h3C, 8'h3C, 8'h3C, 8'h3C};
      shift_byte(8'h3C);
      for (int i = 0; i < 4; i++) begin
         edge_with(1'b1, 1'b1, 1'b1);
         tests_run++;
         if (out !== exp_after[i]) begin
            tests_failed++;
            $display("FAIL strobe_hold_%0d: got %h, required %h", i, out, exp_after[i]);
         end
      end
      // five ones shifted into 0x3C gives 8'hF9, latched on the next rise
      edge_with(1'b1, 1'b1, 1'b0);
      edge_with(1'b1, 1'b0, 1'b1);
      tests_run++;
      if (out !== 8'hF9) begin
         tests_failed++;
         $display("FAIL strobe_rearm: got %h, required %h", out, 8'hF9);
      end
      edge_with(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_priority();
      shift_byte(8'hFF);
      edge_with(1'b0, 1'b1, 1'b1);
      tests_run++;
      if (out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_vs_strobe: got %h, required %h", out, 8'h00);
      end
      edge_with(1'b1, 1'b0, 1'b0);
      edge_with(1'b1, 1'b0, 1'b1);
      tests_run++;
      if (out !== 8'h00) begin
         tests_failed++;
         $display("FAIL strobe_after_reset: got %h, required %h", out, 8'h00);
      end
      edge_with(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_mid_byte_reset();
      edge_with(1'b1, 1'b1, 1'b0);
      edge_with(1'b1, 1'b1, 1'b0);
      edge_with(1'b1, 1'b1, 1'b0);
      edge_with(1'b0, 1'b1, 1'b0);
      // 0,0,0,0,0,0,0,1 first to last
      shift_byte(8'b1000_0000);
      strobe();
      tests_run++;
      if (out !== 8'b1000_0000) begin
         tests_failed++;
         $display("FAIL mid_byte_reset: got %b, required %b", out, 8'b1000_0000);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      MR_bar       = 1'b0;
      bus.DS       = 1'b0;
      bus.STCP     = 1'b0;
      bus.OE_bar   = 1'b1;
      @(posedge SHCP);
      #1;
      test_reset();
      test_shift();
      test_bit_order();
      test_output_enable();
      test_strobe_hold();
      test_reset_priority();
      test_mid_byte_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_shift_register_sipo
